serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             br_reg;
  logic             borrow_out_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow_reg;
`endif

  // One full-subtractor cell, reused across bits via the counter-selected operand bits.
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  assign a_bit   = a_reg[cnt_reg];
  assign b_bit   = b_reg[cnt_reg];
  assign d_bit   = a_bit ^ b_bit ^ br_reg;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      diff_reg       <= '0;
      cnt_reg        <= '0;
      br_reg         <= 1'b0;
      borrow_out_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            br_reg       <= borrow_in;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          // Shift in from the MSB end so bit 0 lands at position 0 after WIDTH steps.
          diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg      <= DONE;
            out_valid_reg  <= 1'b1;
            borrow_out_reg <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last step a_bit/b_bit are the sign bits and d_bit is the result sign.
            overflow_reg   <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow   = overflow_reg;
`endif

endmodule
